// File: rtl/cas_key_pkg.sv
// ============================================================================
// Module      : cas_key_pkg
// Description : Shared FSM state encoding, default widths and checksum helper
//               for the CAS-Lock key loader.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package cas_key_pkg;

    localparam int KEY_W_DEF = 64;
    localparam int CHK_W     = 8;
    // Upper bound on key width accepted by xor_bytes; narrower keys are zero-extended
    localparam int KEY_W_MAX = 2048;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_ARMED = 3'd3,
        ST_ERROR = 3'd4
    } state_e;

    function automatic logic [CHK_W-1:0] xor_bytes(input logic [KEY_W_MAX-1:0] key);
        logic [CHK_W-1:0] acc;
        acc = '0;
        for (int b = 0; b < KEY_W_MAX / 8; b++) begin
            acc = acc ^ key[b*8 +: 8];
        end
        return acc;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cas_key_shift.sv
// ============================================================================
// Module      : cas_key_shift
// Description : LSB-first serial-to-parallel shadow register for the key and
//               its checksum, with bit counter and sticky load-done flag.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cas_key_shift
    import cas_key_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             bit_en,
    input  logic             bit_in,
    output logic [KEY_W-1:0] shadow,
    output logic [CHK_W-1:0] chk,
    output logic             done
);

    localparam int               CNT_W    = $clog2(KEY_W + CHK_W + 1);
    localparam logic [CNT_W-1:0] KEY_CNT  = CNT_W'(KEY_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(KEY_W + CHK_W - 1);

    logic [KEY_W-1:0] shadow_q, shadow_d;
    logic [CHK_W-1:0] chk_q, chk_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    always_comb begin
        shadow_d = shadow_q;
        chk_d    = chk_q;
        cnt_d    = cnt_q;
        done_d   = done_q;
        if (clear) begin
            shadow_d = '0;
            chk_d    = '0;
            cnt_d    = '0;
            done_d   = 1'b0;
        end else if (bit_en && !done_q) begin
            // Right-shift insertion: after KEY_W shifts, the first bit sits at shadow[0]
            if (cnt_q < KEY_CNT) begin
                shadow_d = {bit_in, shadow_q[KEY_W-1:1]};
            end else begin
                chk_d = {bit_in, chk_q[CHK_W-1:1]};
            end
            cnt_d  = cnt_q + CNT_W'(1);
            done_d = (cnt_q == LAST_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            chk_q    <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            chk_q    <= chk_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    assign shadow = shadow_q;
    assign chk    = chk_q;
    assign done   = done_q;

endmodule

`default_nettype wire

// File: rtl/cas_key_loader.sv
// ============================================================================
// Module      : cas_key_loader
// Description : Serial key loader for a CAS-Lock locked core. Verifies a
//               byte-wise XOR checksum before driving the key bus.
//               Optional macro CAS_KEY_ZEROIZE_EN adds a zeroize input.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cas_key_loader
    import cas_key_pkg::*;
#(
    parameter int KEY_W   = KEY_W_DEF,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             key_sdata,
    input  logic             key_svalid,
`ifdef CAS_KEY_ZEROIZE_EN
    input  logic             zeroize,
`endif
    output logic             key_sready,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic             key_err,
    output logic             busy
);

    localparam int               TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [KEY_W-1:0] key_out_q, key_out_d;
    logic             key_valid_q, key_valid_d;
    logic             key_err_q, key_err_d;

    logic [KEY_W-1:0] shadow;
    logic [CHK_W-1:0] chk;
    logic             load_done;
    logic             sready;
    logic             xfer;
    logic             clear;

    cas_key_shift #(
        .KEY_W (KEY_W)
    ) u_shift (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .bit_en (xfer),
        .bit_in (key_sdata),
        .shadow (shadow),
        .chk    (chk),
        .done   (load_done)
    );

    // Stop accepting once the full frame is in, while the FSM moves to CHECK
    assign sready = (state_q == ST_LOAD) && !load_done;
    assign xfer   = key_svalid && sready;

    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        key_out_d   = key_out_q;
        key_valid_d = key_valid_q;
        key_err_d   = key_err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (load_done) begin
                    state_d = ST_CHECK;
                end else if (xfer) begin
                    tmo_d = '0;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_ERROR;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_CHECK: begin
                if (xor_bytes(KEY_W_MAX'(shadow)) == chk) begin
                    state_d     = ST_ARMED;
                    key_out_d   = shadow;
                    key_valid_d = 1'b1;
                end else begin
                    state_d = ST_ERROR;
                end
            end
            ST_ARMED, ST_ERROR: begin
                if (start) state_d = ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef CAS_KEY_ZEROIZE_EN
        if (zeroize) state_d = ST_ERROR;
`endif

        if (state_d == ST_ERROR) begin
            key_out_d   = '0;
            key_valid_d = 1'b0;
            key_err_d   = 1'b1;
        end else if (state_d == ST_LOAD && state_q != ST_LOAD) begin
            key_out_d   = '0;
            key_valid_d = 1'b0;
            key_err_d   = 1'b0;
        end

        if (state_d != ST_LOAD) tmo_d = '0;
    end

    // Shadow survives LOAD->CHECK->ARMED; wiped on any fresh load, abort or idle
    assign clear = (state_d == ST_ERROR) || (state_d == ST_IDLE) ||
                   (state_d == ST_LOAD && state_q != ST_LOAD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tmo_q       <= '0;
            key_out_q   <= '0;
            key_valid_q <= 1'b0;
            key_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            key_out_q   <= key_out_d;
            key_valid_q <= key_valid_d;
            key_err_q   <= key_err_d;
        end
    end

    assign key_sready = sready;
    assign key_out    = key_out_q;
    assign key_valid  = key_valid_q;
    assign key_err    = key_err_q;
    assign busy       = (state_q == ST_LOAD) || (state_q == ST_CHECK);

endmodule

`default_nettype wire

// File: tb/tb_cas_key_loader.sv
// ============================================================================
// Module      : tb_cas_key_loader
// Description : Directed self-checking bench for cas_key_loader.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cas_key_loader;

    localparam int KEY_W   = 64;
    localparam int TIMEOUT = 16;

    localparam logic [63:0] KEY_GOOD = 64'hA5A5_0000_0000_0001;
    localparam logic [7:0]  CHK_GOOD = 8'h01;
    localparam logic [63:0] KEY_TWO  = 64'h0123_4567_89AB_CDEF;
    localparam logic [7:0]  CHK_TWO  = 8'h00;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             key_sdata;
    logic             key_svalid;
`ifdef CAS_KEY_ZEROIZE_EN
    logic             zeroize;
`endif
    logic             key_sready;
    logic [KEY_W-1:0] key_out;
    logic             key_valid;
    logic             key_err;
    logic             busy;
    logic [3:0]       status;

    int n_cmp = 0;
    int n_bad = 0;

    cas_key_loader #(
        .KEY_W   (KEY_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .key_sdata  (key_sdata),
        .key_svalid (key_svalid),
`ifdef CAS_KEY_ZEROIZE_EN
        .zeroize    (zeroize),
`endif
        .key_sready (key_sready),
        .key_out    (key_out),
        .key_valid  (key_valid),
        .key_err    (key_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    assign status = {key_valid, key_err, busy, key_sready};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Streams key then checksum LSB-first; start is raised alongside bit start_at
    task automatic stream(input logic [63:0] key, input logic [7:0] chk, input int start_at);
        logic [71:0] frame;
        frame = {chk, key};
        for (int i = 0; i < 72; i++) begin
            key_sdata  = frame[i];
            key_svalid = 1'b1;
            start      = (i == start_at);
            tick();
        end
        key_svalid = 1'b0;
        key_sdata  = 1'b0;
        start      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; key_sdata = 1'b0; key_svalid = 1'b0;
`ifdef CAS_KEY_ZEROIZE_EN
        zeroize = 1'b0;
`endif
        tick(); tick();
        rst = 1'b0;
        n_cmp++;
        if (key_out !== 64'h0) begin
            n_bad++; $display("FAIL reset_key_out: got %h expected %h", key_out, 64'h0);
        end
        n_cmp++;
        if (status !== 4'b0000) begin
            n_bad++; $display("FAIL reset_status: got %b expected %b", status, 4'b0000);
        end
        // Bits offered in IDLE must not be consumed
        key_svalid = 1'b1; key_sdata = 1'b1;
        tick(); tick(); tick();
        n_cmp++;
        if (key_sready !== 1'b0) begin
            n_bad++; $display("FAIL idle_sready: got %b expected %b", key_sready, 1'b0);
        end
        key_svalid = 1'b0; key_sdata = 1'b0;
    endtask

    task automatic test_good_key();
        pulse_start();
        n_cmp++;
        if (status !== 4'b0011) begin
            n_bad++; $display("FAIL good_load_status: got %b expected %b", status, 4'b0011);
        end
        stream(KEY_GOOD, CHK_GOOD, -1);
        n_cmp++;
        if (status !== 4'b0010) begin
            n_bad++; $display("FAIL good_after_last_bit: got %b expected %b", status, 4'b0010);
        end
        tick();
        n_cmp++;
        if (status !== 4'b0010 || key_out !== 64'h0) begin
            n_bad++; $display("FAIL good_check_cycle: got %b/%h expected %b/%h", status, key_out, 4'b0010, 64'h0);
        end
        tick();
        n_cmp++;
        if (status !== 4'b1000) begin
            n_bad++; $display("FAIL good_armed_status: got %b expected %b", status, 4'b1000);
        end
        n_cmp++;
        if (key_out !== KEY_GOOD) begin
            n_bad++; $display("FAIL good_key_out: got %h expected %h", key_out, KEY_GOOD);
        end
        key_svalid = 1'b1; key_sdata = 1'b1;
        repeat (4) tick();
        key_svalid = 1'b0; key_sdata = 1'b0;
        n_cmp++;
        if (key_out !== KEY_GOOD || key_valid !== 1'b1) begin
            n_bad++; $display("FAIL armed_hold: got %h/%b expected %h/%b", key_out, key_valid, KEY_GOOD, 1'b1);
        end
    endtask

    task automatic test_bad_checksum();
        pulse_start();
        n_cmp++;
        if (status !== 4'b0011 || key_out !== 64'h0) begin
            n_bad++; $display("FAIL bad_restart: got %b/%h expected %b/%h", status, key_out, 4'b0011, 64'h0);
        end
        stream(KEY_GOOD, 8'h00, -1);
        tick(); tick();
        n_cmp++;
        if (status !== 4'b0100) begin
            n_bad++; $display("FAIL bad_status: got %b expected %b", status, 4'b0100);
        end
        n_cmp++;
        if (key_out !== 64'h0) begin
            n_bad++; $display("FAIL bad_key_out: got %h expected %h", key_out, 64'h0);
        end
    endtask

    task automatic test_timeout();
        logic [63:0] k;
        k = KEY_TWO;
        pulse_start();
        n_cmp++;
        if (status !== 4'b0011) begin
            n_bad++; $display("FAIL tmo_restart_from_error: got %b expected %b", status, 4'b0011);
        end
        for (int i = 0; i < 10; i++) begin
            key_sdata = k[i]; key_svalid = 1'b1;
            tick();
        end
        key_svalid = 1'b0; key_sdata = 1'b0;
        repeat (TIMEOUT - 1) tick();
        n_cmp++;
        if (status !== 4'b0011) begin
            n_bad++; $display("FAIL tmo_not_yet: got %b expected %b", status, 4'b0011);
        end
        tick();
        n_cmp++;
        if (status !== 4'b0100 || key_out !== 64'h0) begin
            n_bad++; $display("FAIL tmo_expired: got %b/%h expected %b/%h", status, key_out, 4'b0100, 64'h0);
        end
    endtask

    task automatic test_reload();
        pulse_start();
        stream(KEY_GOOD, CHK_GOOD, -1);
        tick(); tick();
        n_cmp++;
        if (key_out !== KEY_GOOD || status !== 4'b1000) begin
            n_bad++; $display("FAIL reload_first: got %h/%b expected %h/%b", key_out, status, KEY_GOOD, 4'b1000);
        end
        pulse_start();
        n_cmp++;
        if (key_out !== 64'h0 || status !== 4'b0011) begin
            n_bad++; $display("FAIL reload_clear: got %h/%b expected %h/%b", key_out, status, 64'h0, 4'b0011);
        end
        // start mid-stream must be ignored
        stream(KEY_TWO, CHK_TWO, 20);
        tick(); tick();
        n_cmp++;
        if (key_out !== KEY_TWO || status !== 4'b1000) begin
            n_bad++; $display("FAIL reload_second: got %h/%b expected %h/%b", key_out, status, KEY_TWO, 4'b1000);
        end
    endtask

    task automatic test_reset_mid_load();
        logic [63:0] k;
        k = KEY_TWO;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (key_out !== 64'h0 || status !== 4'b0000) begin
            n_bad++; $display("FAIL rst_armed: got %h/%b expected %h/%b", key_out, status, 64'h0, 4'b0000);
        end
        pulse_start();
        for (int i = 0; i < 40; i++) begin
            key_sdata = k[i]; key_svalid = 1'b1;
            tick();
        end
        key_svalid = 1'b0; key_sdata = 1'b0;
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        n_cmp++;
        if (status !== 4'b0000) begin
            n_bad++; $display("FAIL rst_beats_start: got %b expected %b", status, 4'b0000);
        end
        pulse_start();
        stream(KEY_GOOD, CHK_GOOD, -1);
        tick(); tick();
        n_cmp++;
        if (key_out !== KEY_GOOD || status !== 4'b1000) begin
            n_bad++; $display("FAIL rst_reload: got %h/%b expected %h/%b", key_out, status, KEY_GOOD, 4'b1000);
        end
    endtask

`ifdef CAS_KEY_ZEROIZE_EN
    task automatic test_zeroize();
        zeroize = 1'b1; start = 1'b1;
        tick();
        zeroize = 1'b0; start = 1'b0;
        n_cmp++;
        if (status !== 4'b0100 || key_out !== 64'h0) begin
            n_bad++; $display("FAIL zeroize: got %b/%h expected %b/%h", status, key_out, 4'b0100, 64'h0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_good_key();
        test_bad_checksum();
        test_timeout();
        test_reload();
        test_reset_mid_load();
`ifdef CAS_KEY_ZEROIZE_EN
        test_zeroize();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
